module_alu_sequencer: RTL and testbench

//  Initiator side of the module_alu interface: collects operand A, operand B and opcode/carry

---
 rtl/module_alu_sequencer_pkg.sv | 23 ++
 rtl/module_alu_sequencer.sv | 131 +++++++++++++
 tb/tb_module_alu_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/module_alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: operand type, opcode type, last legal opcode and FSM states.
package pkg_bits;

  localparam int BITS_W = 8;

  typedef logic [BITS_W-1:0] bits_t;
  typedef logic [3:0]        alu_op_t;

  localparam alu_op_t ALU_OP_LAST = 4'hA;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } seq_state_e;

  function automatic logic op_legal(input alu_op_t op);
    return op <= ALU_OP_LAST;
  endfunction

endpackage

// File: rtl/module_alu_sequencer.sv
// Loads A, B and opcode/carry from switches, drives a combinational ALU and captures its outputs.
// Optional ALU_SEQ_ACC_EN: the strobe in DONE feeds the last result back as operand A.
module module_alu_sequencer
  import pkg_bits::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             load_i,
  output logic             ready_o,
  output logic [2:0]       state_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic             alu_flag_in_o,
  output logic [3:0]       alu_control_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_flags_i,
  input  logic             alu_zero_i,
  output logic [WIDTH-1:0] result_o,
  output logic             flags_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             err_o
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_flag_in_q, alu_flag_in_d;
  alu_op_t          alu_control_q, alu_control_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flags_q, flags_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  alu_op_t          op_in;

  assign op_in = alu_op_t'(data_i[3:0]);

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_flag_in_d = alu_flag_in_q;
    alu_control_d = alu_control_q;
    result_d      = result_q;
    flags_d       = flags_q;
    zero_d        = zero_q;
    valid_d       = valid_q;
    err_d         = 1'b0;
    case (state_q)
      LOAD_A: if (load_i) begin
        alu_a_d = data_i;
        state_d = LOAD_B;
      end
      LOAD_B: if (load_i) begin
        alu_b_d = data_i;
        state_d = LOAD_OP;
      end
      LOAD_OP: if (load_i) begin
        // An illegal opcode leaves the ALU inputs alone so the previous setup stays intact.
        if (op_legal(op_in)) begin
          alu_control_d = op_in;
          alu_flag_in_d = data_i[4];
          state_d       = EXEC;
        end else begin
          err_d = 1'b1;
        end
      end
      EXEC: begin
        result_d = alu_result_i;
        flags_d  = alu_flags_i;
        zero_d   = alu_zero_i;
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      DONE: if (load_i) begin
        valid_d = 1'b0;
`ifdef ALU_SEQ_ACC_EN
        alu_a_d = result_q;
        state_d = LOAD_B;
`else
        state_d = LOAD_A;
`endif
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= LOAD_A;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_flag_in_q <= 1'b0;
      alu_control_q <= '0;
      result_q      <= '0;
      flags_q       <= 1'b0;
      zero_q        <= 1'b0;
      valid_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_flag_in_q <= alu_flag_in_d;
      alu_control_q <= alu_control_d;
      result_q      <= result_d;
      flags_q       <= flags_d;
      zero_q        <= zero_d;
      valid_q       <= valid_d;
      err_q         <= err_d;
    end
  end

  assign ready_o       = (state_q == LOAD_A) || (state_q == LOAD_B) ||
                         (state_q == LOAD_OP) || (state_q == DONE);
  assign state_o       = state_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_flag_in_o = alu_flag_in_q;
  assign alu_control_o = alu_control_q;
  assign result_o      = result_q;
  assign flags_o       = flags_q;
  assign zero_o        = zero_q;
  assign valid_o       = valid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_module_alu_sequencer.sv
// Bench for module_alu_sequencer with a behavioural ALU on its ALU ports and a result scoreboard.
module tb_module_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       load_i = 1'b0;
  logic       ready_o;
  logic [2:0] state_o;
  logic [7:0] alu_a_o, alu_b_o;
  logic       alu_flag_in_o;
  logic [3:0] alu_control_o;
  logic [7:0] alu_result_i;
  logic       alu_flags_i, alu_zero_i;
  logic [7:0] result_o;
  logic       flags_o, zero_o, valid_o, err_o;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  logic       valid_seen = 1'b0;
  logic [7:0] model_a, model_b;

  always #5 clk = ~clk;

  module_alu_sequencer #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .load_i(load_i),
    .ready_o(ready_o), .state_o(state_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_flag_in_o(alu_flag_in_o), .alu_control_o(alu_control_o),
    .alu_result_i(alu_result_i), .alu_flags_i(alu_flags_i), .alu_zero_i(alu_zero_i),
    .result_o(result_o), .flags_o(flags_o), .zero_o(zero_o),
    .valid_o(valid_o), .err_o(err_o)
  );

  // Behavioural ALU: returns {zero, flag, result}.
  function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op, input logic cin);
    logic [8:0] t;
    case (op)
      4'h0:    t = {1'b0, a} + {1'b0, b} + {8'b0, cin};
      4'h1:    t = {1'b0, a} - {1'b0, b};
      4'h2:    t = {1'b0, a & b};
      4'h3:    t = {1'b0, a | b};
      4'h4:    t = {1'b0, a ^ b};
      4'h5:    t = {1'b0, ~a};
      4'h6:    t = {a, 1'b0};
      4'h7:    t = {a[0], 1'b0, a[7:1]};
      4'h8:    t = {1'b0, a} + 9'd1;
      4'h9:    t = {1'b0, a} - 9'd1;
      4'hA:    t = {1'b0, b};
      default: t = 9'h000;
    endcase
    return {(t[7:0] == 8'h00), t[8], t[7:0]};
  endfunction

  always_comb begin
    {alu_zero_i, alu_flags_i, alu_result_i} = alu_ref(alu_a_o, alu_b_o, alu_control_o, alu_flag_in_o);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each fresh valid result is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (valid_o && !valid_seen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("result", {24'b0, result_o}, {24'b0, e[7:0]});
        chk("flags", {31'b0, flags_o}, {31'b0, e[8]});
        chk("zero", {31'b0, zero_o}, {31'b0, e[9]});
      end
    end
    valid_seen = valid_o;
  end

  task automatic strobe(input logic [7:0] d);
    @(negedge clk);
    data_i = d;
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, {29'b0, state_o}, 32'd0);
    chk({tag, "_outs"}, {alu_a_o, alu_b_o, alu_control_o, alu_flag_in_o, result_o[2:0]}, 32'd0);
    chk({tag, "_res"}, {21'b0, result_o, flags_o, zero_o, valid_o}, 32'd0);
    chk({tag, "_err"}, {31'b0, err_o}, 32'd0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic cin, input logic load_in_exec);
    logic [9:0] e;
    if (state_o == 3'd0) begin
      chk("ready_a", {31'b0, ready_o}, 32'd1);
      strobe(a);
      model_a = a;
    end
    chk("state_b", {29'b0, state_o}, 32'd1);
    strobe(b);
    model_b = b;
    chk("state_op", {29'b0, state_o}, 32'd2);
    strobe({3'b000, cin, op});
    chk("state_exec", {29'b0, state_o}, 32'd3);
    chk("ready_exec", {31'b0, ready_o}, 32'd0);
    chk("exec_ops", {8'b0, alu_a_o, alu_b_o, 3'b0, alu_flag_in_o, alu_control_o},
        {8'b0, model_a, model_b, 3'b0, cin, op});
    e = alu_ref(model_a, model_b, op, cin);
    exp_q.push_back(e);
    if (load_in_exec) begin
      data_i = 8'($urandom);
      load_i = 1'b1;
    end
    @(negedge clk);
    load_i = 1'b0;
    chk("state_done", {29'b0, state_o}, 32'd4);
    chk("valid_done", {31'b0, valid_o}, 32'd1);
    strobe(8'($urandom));
    chk("valid_clear", {31'b0, valid_o}, 32'd0);
`ifdef ALU_SEQ_ACC_EN
    chk("acc_state", {29'b0, state_o}, 32'd1);
    chk("acc_a", {24'b0, alu_a_o}, {24'b0, e[7:0]});
    model_a = e[7:0];
`else
    chk("state_back", {29'b0, state_o}, 32'd0);
    chk("a_kept", {24'b0, alu_a_o}, {24'b0, model_a});
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    chk_all_zero("reset");

    // Directed: add with carry in.
    run_op(8'hFA, 8'h0F, 4'h0, 1'b1, 1'b0);

    // Opcode sweep.
    for (int op = 0; op <= 10; op++) run_op(8'hFA, 8'h0F, 4'(op), 1'b0, 1'b0);

    // Illegal opcode, then a legal one.
    if (state_o == 3'd0) begin
      strobe(8'h33);
      model_a = 8'h33;
    end
    strobe(8'h44);
    model_b = 8'h44;
    begin
      logic [3:0] ctl_before;
      ctl_before = alu_control_o;
      strobe(8'h0B);
      chk("err_pulse", {31'b0, err_o}, 32'd1);
      chk("err_state", {29'b0, state_o}, 32'd2);
      chk("err_valid", {31'b0, valid_o}, 32'd0);
      chk("err_ctl", {28'b0, alu_control_o}, {28'b0, ctl_before});
      @(negedge clk);
      chk("err_clear", {31'b0, err_o}, 32'd0);
    end
    strobe(8'h01);
    chk("after_err_exec", {29'b0, state_o}, 32'd3);
    exp_q.push_back(alu_ref(model_a, model_b, 4'h1, 1'b0));
    @(negedge clk);
    chk("after_err_done", {29'b0, state_o}, 32'd4);
    strobe(8'h00);

    // Load during EXEC is ignored.
    run_op(8'h81, 8'h7F, 4'h0, 1'b1, 1'b1);

    // Randomised operations.
    for (int i = 0; i < 25; i++)
      run_op(8'($urandom), 8'($urandom), 4'($urandom_range(0, 10)), 1'($urandom), 1'($urandom));

    // Reset mid-operation.
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    strobe(8'h55);
    chk("mid_a", {24'b0, alu_a_o}, 32'h55);
    chk("mid_state", {29'b0, state_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk_all_zero("midreset");

    run_op(8'h00, 8'h00, 4'h4, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
